enc_width_down_converter: RTL and testbench
===========================================

ENC_WIDTH_DOWN_CONVERTER -- requirements
Module: enc_width_down_converter

Interface
REQ-001 SHALL have parameter InputDataWidth, default 32, source word width in bits.
REQ-002 SHALL have parameter OutputDataWidth, default 16, output beat width in bits; InputDataWidth = Ratio x OutputDataWidth, integer Ratio from 2 to 16.
REQ-003 SHALL have parameter MSBFirst, default 1: 1 emits most significant slice first, 0 emits least significant slice first.
REQ-004 SHALL have port iClock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port iReset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iSrcDataValid  input  1  source word valid.
REQ-007 SHALL have port iSrcDataLast  input  1  word is final word of packet.
REQ-008 SHALL have port iSrcBeatCount  input  clog2(Ratio)+1  valid beats in word, sampled only when iSrcDataLast=1; 0 or >Ratio treated as Ratio.
REQ-009 SHALL have port iSrcData  input  InputDataWidth  source word.
REQ-010 SHALL have port oConverterReady  output  1  word accepted when iSrcDataValid & oConverterReady.
REQ-011 SHALL have port oConvertedDataValid  output  1  beat valid.
REQ-012 SHALL have port oConvertedDataLast  output  1  final beat of packet.
REQ-013 SHALL have port oConvertedData  output  OutputDataWidth  beat data.
REQ-014 SHALL have port iDstReady  input  1  beat consumed when oConvertedDataValid & iDstReady.

Function
REQ-015 SHALL implement two states: EMPTY (no word held) and BUSY (word held, beats pending).
REQ-016 SHALL drive oConverterReady = 1 in EMPTY, and in BUSY only in the cycle the final pending beat is consumed; this is the only combinational path from iDstReady.
REQ-017 SHALL on acceptance capture iSrcData into holding register, set beat index 0, set beat limit = Ratio (or iSrcBeatCount per REQ-008 when last), capture last flag, enter BUSY.
REQ-018 SHALL have one-cycle latency: word accepted at edge N, first beat valid after edge N.
REQ-019 SHALL select beat k as slice [InputDataWidth-1-k*OutputDataWidth -: OutputDataWidth] when MSBFirst=1, [k*OutputDataWidth +: OutputDataWidth] when MSBFirst=0; oConvertedData driven from registers only.
REQ-020 SHALL hold oConvertedDataValid high and oConvertedData/oConvertedDataLast stable in BUSY until consumed (no drop under backpressure).
REQ-021 SHALL increment beat index on each consumed beat; on consuming beat (limit-1) go to EMPTY, or stay BUSY with the new word if accepted same cycle (zero-bubble back-to-back).
REQ-022 SHALL assert oConvertedDataLast only on beat (limit-1) of a word captured with iSrcDataLast=1; never on other beats.
REQ-023 SHALL drive oConvertedDataValid = 0 in EMPTY; oConvertedData is don't-care then but SHALL be stable (last-held value).
REQ-024 SHALL ignore iSrcData, iSrcDataLast, iSrcBeatCount when not accepted.
REQ-025 SHALL sustain one beat per cycle when iSrcDataValid and iDstReady stay high.

Reset
REQ-026 SHALL, while iReset=0, force EMPTY, beat index 0, holding register 0, oConvertedDataValid 0, oConvertedDataLast 0, oConvertedData 0, oConverterReady 0.
REQ-027 SHALL on reset assertion mid-word discard held word immediately (asynchronously); after deassertion resume in EMPTY with oConverterReady 1.
REQ-028 SHALL release reset synchronously to iClock; no acceptance on the deassertion edge.

Verification
REQ-029 Defaults, iSrcData=0xAABBCCDD, last=0, iDstReady=1 -> beats 0xAABB, 0xCCDD on consecutive cycles, last=0, ready high in second beat cycle.
REQ-030 Words 0x11112222, 0x33334444 back-to-back, iDstReady=1 -> 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles, no bubbles.
REQ-031 iDstReady low 3 cycles during beat 0x1111 -> valid held, data 0x1111 stable, ready 0, no loss, then sequence resumes.
REQ-032 InputDataWidth=32, OutputDataWidth=8, MSBFirst=0, word 0x04030201, last=1, iSrcBeatCount=3 -> beats 0x01,0x02,0x03, last only on 0x03, then EMPTY.
REQ-033 iReset low after first beat of 0xAABBCCDD -> valid/last/data 0 at once; after release ready=1, no 0xCCDD beat emitted.
REQ-034 Random valid/ready, Ratio 2 and 4, both MSBFirst -> scoreboard output equals sliced input, last count equals input last count.

Source files
------------

// File: rtl/enc_width_down_converter.sv
// Width down-converter: splits each InputDataWidth source word into Ratio beats of
// OutputDataWidth bits. A word is held in a register and emitted one beat per consumed
// cycle. The final word of a packet may carry fewer beats (iSrcBeatCount). The next word
// is accepted in the cycle the final beat leaves, so back-to-back words see no bubble.
//
// Ports:
//   iClock              clock, rising edge
//   iReset              asynchronous active-low reset
//   iSrcDataValid       source word valid
//   iSrcDataLast        source word ends a packet
//   iSrcBeatCount       valid beats in a last word (0 or >Ratio means Ratio)
//   iSrcData            source word
//   oConverterReady     word accepted when iSrcDataValid & oConverterReady
//   oConvertedDataValid beat valid
//   oConvertedDataLast  final beat of packet
//   oConvertedData      beat data (registered)
//   iDstReady           beat consumed when oConvertedDataValid & iDstReady
module enc_width_down_converter #(
  parameter int unsigned InputDataWidth  = 32,
  parameter int unsigned OutputDataWidth = 16,
  parameter bit          MSBFirst        = 1'b1,
  localparam int unsigned Ratio          = InputDataWidth / OutputDataWidth,
  localparam int unsigned CountWidth     = $clog2(Ratio) + 1
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iSrcDataValid,
  input  logic                       iSrcDataLast,
  input  logic [CountWidth-1:0]      iSrcBeatCount,
  input  logic [InputDataWidth-1:0]  iSrcData,
  output logic                       oConverterReady,
  output logic                       oConvertedDataValid,
  output logic                       oConvertedDataLast,
  output logic [OutputDataWidth-1:0] oConvertedData,
  input  logic                       iDstReady
);

  localparam logic [CountWidth-1:0] RatioCount = CountWidth'(Ratio);
  localparam logic [CountWidth-1:0] OneCount   = CountWidth'(1);

  typedef enum logic [0:0] {StEmpty, StBusy} state_e;

  state_e                      state_q;
  logic [InputDataWidth-1:0]   hold_q;
  logic [CountWidth-1:0]       idx_q;
  logic [CountWidth-1:0]       limit_q;
  logic                        last_flag_q;
  logic                        out_last_q;
  logic [OutputDataWidth-1:0]  out_data_q;
  // Low until the first clock edge after reset release, so nothing is accepted on the
  // edge that coincides with deassertion.
  logic                        rst_done_q;

  logic                        beat_taken;
  logic                        final_beat;
  logic                        accept;
  logic [CountWidth-1:0]       new_limit;
  logic [CountWidth-1:0]       idx_next;

  // Beat k of a word, MSB-first or LSB-first.
  function automatic logic [OutputDataWidth-1:0] slice_of(
    input logic [InputDataWidth-1:0] word,
    input logic [CountWidth-1:0]     k
  );
    logic [InputDataWidth-1:0] shifted;
    if (MSBFirst) begin
      shifted = word << (32'(k) * OutputDataWidth);
      return shifted[InputDataWidth-1 -: OutputDataWidth];
    end else begin
      shifted = word >> (32'(k) * OutputDataWidth);
      return shifted[OutputDataWidth-1:0];
    end
  endfunction

  always_comb begin
    new_limit = RatioCount;
    if (iSrcDataLast && (iSrcBeatCount != '0) && (iSrcBeatCount <= RatioCount)) begin
      new_limit = iSrcBeatCount;
    end
  end

  assign idx_next   = idx_q + OneCount;
  assign final_beat = (idx_q == (limit_q - OneCount));
  assign beat_taken = (state_q == StBusy) && iDstReady;
  // iDstReady reaches oConverterReady only through the final-beat term.
  assign oConverterReady = rst_done_q && ((state_q == StEmpty) || (beat_taken && final_beat));
  assign accept          = iSrcDataValid && oConverterReady;

  assign oConvertedDataValid = (state_q == StBusy);
  assign oConvertedDataLast  = out_last_q;
  assign oConvertedData      = out_data_q;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q     <= StEmpty;
      hold_q      <= '0;
      idx_q       <= '0;
      limit_q     <= RatioCount;
      last_flag_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) begin
        state_q     <= StBusy;
        hold_q      <= iSrcData;
        idx_q       <= '0;
        limit_q     <= new_limit;
        last_flag_q <= iSrcDataLast;
        out_data_q  <= slice_of(iSrcData, '0);
        out_last_q  <= iSrcDataLast && (new_limit == OneCount);
      end else if (beat_taken) begin
        if (final_beat) begin
          // out_data_q keeps its last value while empty.
          state_q    <= StEmpty;
          out_last_q <= 1'b0;
        end else begin
          idx_q      <= idx_next;
          out_data_q <= slice_of(hold_q, idx_next);
          out_last_q <= last_flag_q && (idx_next == (limit_q - OneCount));
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_width_down_converter.sv
// Bench for enc_width_down_converter: four instances (32->16 and 32->8, MSB- and
// LSB-first), directed cycle checks plus a random valid/ready scoreboard run on each.
module tb_enc_width_down_converter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src_valid = 1'b0;
  logic        src_last = 1'b0;
  logic [4:0]  src_cnt = '0;
  logic [31:0] src_data = '0;
  logic        dst_ready = 1'b0;
  int          sel = 0;

  logic [N-1:0] rdy, ov, ol;
  logic [15:0]  od [N];

  always #5 clk = ~clk;

  // Instance g: g<2 -> 16-bit beats, else 8-bit; even g -> MSB first.
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned Ow  = (g < 2) ? 16 : 8;
    localparam bit          Msb = ((g % 2) == 0);
    localparam int unsigned Cw  = $clog2(32 / Ow) + 1;
    logic [Ow-1:0] d;
    enc_width_down_converter #(
      .InputDataWidth (32),
      .OutputDataWidth(Ow),
      .MSBFirst       (Msb)
    ) u_dut (
      .iClock             (clk),
      .iReset             (rst_n),
      .iSrcDataValid      (src_valid && (sel == g)),
      .iSrcDataLast       (src_last),
      .iSrcBeatCount      (src_cnt[Cw-1:0]),
      .iSrcData           (src_data),
      .oConverterReady    (rdy[g]),
      .oConvertedDataValid(ov[g]),
      .oConvertedDataLast (ol[g]),
      .oConvertedData     (d),
      .iDstReady          (dst_ready)
    );
    assign od[g] = 16'(d);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    last_in = 0;
  int    last_out = 0;

  // Expected beats of one accepted word, from the instance's geometry.
  task automatic push_word(input int s, input logic [31:0] w, input logic lf, input int c);
    int    ow;
    int    r;
    int    cw;
    int    cc;
    int    lim;
    bit    msb;
    logic [31:0] v;
    beat_t e;
    ow  = (s < 2) ? 16 : 8;
    msb = ((s % 2) == 0);
    r   = 32 / ow;
    cw  = (r == 2) ? 2 : 3;
    cc  = c % (1 << cw);
    lim = r;
    if (lf && cc != 0 && cc <= r) lim = cc;
    for (int k = 0; k < lim; k++) begin
      v   = msb ? (w >> (32 - (k + 1) * ow)) : (w >> (k * ow));
      v   = v & ((32'd1 << ow) - 32'd1);
      e.d = v[15:0];
      e.l = lf && (k == lim - 1);
      exp_q.push_back(e);
    end
  endtask

  // Inputs are stable at the falling edge, so handshakes seen here complete at the next
  // rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (ov[sel] && dst_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_data", 32'(od[sel]), 32'(e.d));
          check_val("sb_last", 32'(ol[sel]), 32'(e.l));
          if (ol[sel]) last_out++;
        end
      end
      if (src_valid && rdy[sel]) begin
        push_word(sel, src_data, src_last, int'(src_cnt));
        if (src_last) last_in++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] d, input logic l,
                             input logic r);
    check_val({tag, "_valid"}, 32'(ov[sel]), 32'd1);
    check_val({tag, "_data"},  32'(od[sel]), 32'(d));
    check_val({tag, "_last"},  32'(ol[sel]), 32'(l));
    check_val({tag, "_ready"}, 32'(rdy[sel]), 32'(r));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      check_val("rst_ready", 32'(rdy[i]), 32'd0);
      check_val("rst_valid", 32'(ov[i]), 32'd0);
      check_val("rst_last",  32'(ol[i]), 32'd0);
      check_val("rst_data",  32'(od[i]), 32'd0);
    end
    rst_n = 1'b1;
    step();
    check_val("ready_after_rst", 32'(rdy[0]), 32'd1);

    // Basic split, 32->16 MSB first
    sel = 0;
    src_valid = 1'b1; src_data = 32'hAABBCCDD; src_last = 1'b0; dst_ready = 1'b1;
    step();
    src_valid = 1'b0;
    expect_beat("basic_b0", 16'hAABB, 1'b0, 1'b0);
    step();
    expect_beat("basic_b1", 16'hCCDD, 1'b0, 1'b1);
    step();
    check_val("basic_idle", 32'(ov[0]), 32'd0);

    // Back-to-back words, no bubbles
    src_valid = 1'b1; src_data = 32'h11112222;
    step();
    expect_beat("b2b_0", 16'h1111, 1'b0, 1'b0);
    src_data = 32'h33334444;
    step();
    expect_beat("b2b_1", 16'h2222, 1'b0, 1'b1);
    step();
    src_valid = 1'b0;
    expect_beat("b2b_2", 16'h3333, 1'b0, 1'b0);
    step();
    expect_beat("b2b_3", 16'h4444, 1'b0, 1'b1);
    step();
    check_val("b2b_idle", 32'(ov[0]), 32'd0);

    // Backpressure holds the beat
    src_valid = 1'b1; src_data = 32'h11112222;
    step();
    src_valid = 1'b0; dst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_beat("stall", 16'h1111, 1'b0, 1'b0);
      step();
    end
    dst_ready = 1'b1;
    expect_beat("stall_rel", 16'h1111, 1'b0, 1'b0);
    step();
    expect_beat("stall_b1", 16'h2222, 1'b0, 1'b1);
    step();
    check_val("stall_idle", 32'(ov[0]), 32'd0);

    // Short last word, 32->8 LSB first, 3 beats
    sel = 3;
    src_valid = 1'b1; src_data = 32'h04030201; src_last = 1'b1; src_cnt = 5'd3;
    step();
    src_valid = 1'b0; src_last = 1'b0; src_cnt = 5'd0;
    expect_beat("short_0", 16'h01, 1'b0, 1'b0);
    step();
    expect_beat("short_1", 16'h02, 1'b0, 1'b0);
    step();
    expect_beat("short_2", 16'h03, 1'b1, 1'b1);
    step();
    check_val("short_idle", 32'(ov[3]), 32'd0);
    check_val("short_q", 32'(exp_q.size()), 32'd0);

    // Random valid/ready on every instance
    for (int s = 0; s < N; s++) begin
      sel = s; last_in = 0; last_out = 0;
      for (int i = 0; i < 300; i++) begin
        src_valid = 1'($urandom_range(0, 1));
        src_last  = ($urandom_range(0, 3) == 0);
        src_cnt   = 5'($urandom_range(0, 7));
        src_data  = $urandom;
        dst_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      src_valid = 1'b0; dst_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
      step();
      check_val("rand_drain", 32'(exp_q.size()), 32'd0);
      check_val("rand_lastcnt", 32'(last_out), 32'(last_in));
      check_val("rand_idle", 32'(ov[s]), 32'd0);
    end

    // Reset mid-word discards the held word
    sel = 0; src_last = 1'b0; src_cnt = '0;
    src_valid = 1'b1; src_data = 32'hAABBCCDD; dst_ready = 1'b1;
    step();
    src_valid = 1'b0;
    expect_beat("rmid_b0", 16'hAABB, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check_val("rmid_valid", 32'(ov[0]), 32'd0);
    check_val("rmid_last",  32'(ol[0]), 32'd0);
    check_val("rmid_data",  32'(od[0]), 32'd0);
    check_val("rmid_ready", 32'(rdy[0]), 32'd0);
    exp_q.delete();
    step();
    // Word offered across release must not be taken on the release edge
    src_valid = 1'b1; src_data = 32'h12345678;
    rst_n = 1'b1;
    step();
    check_val("rel_valid", 32'(ov[0]), 32'd0);
    check_val("rel_ready", 32'(rdy[0]), 32'd1);
    step();
    src_valid = 1'b0;
    expect_beat("rel_b0", 16'h1234, 1'b0, 1'b0);
    step();
    expect_beat("rel_b1", 16'h5678, 1'b0, 1'b1);
    step();
    check_val("rel_idle", 32'(ov[0]), 32'd0);
    check_val("rel_q", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
